// File: rtl/ramped_bldc_drive_ctl_if.sv
// Host-side request and drive-status bundle for ramped_bldc_drive_ctl.
// Requests are level-sensitive and sampled on every sys_clk edge. Status outputs are registered.
interface ramped_bldc_drive_ctl_if #(
  parameter int duty_width  = 11,
  parameter int max_retries = 3
);
  logic                                 enable;
  logic [1:0]                           direction;
  logic [duty_width-1:0]                duty_target;
  logic                                 hall_error;
  logic                                 fault_n;
  logic                                 clear_lockout;

  logic [duty_width-1:0]                duty_out;
  logic [1:0]                           dir_out;
  logic                                 pwm_enable;
  logic                                 gate_enable;
  logic                                 gate_reset_pulse;
  logic [$clog2(max_retries+1)-1:0]     retry_count;
  logic                                 lockout;
  logic [2:0]                           driver_state;

  modport master (
    output enable, direction, duty_target, hall_error, fault_n, clear_lockout,
    input  duty_out, dir_out, pwm_enable, gate_enable, gate_reset_pulse,
           retry_count, lockout, driver_state
  );

  modport slave (
    input  enable, direction, duty_target, hall_error, fault_n, clear_lockout,
    output duty_out, dir_out, pwm_enable, gate_enable, gate_reset_pulse,
           retry_count, lockout, driver_state
  );
endinterface

// File: rtl/ramped_bldc_drive_ctl.sv
// BLDC drive sequencer with soft-start/stop duty ramping, a coast dwell on reversal,
// and bounded gate-driver fault retries that end in a host-cleared lockout.
module ramped_bldc_drive_ctl #(
  parameter int duty_width           = 11,
  parameter int ramp_step            = 1,
  parameter int ramp_interval_ticks  = 540,
  parameter int reversal_dwell_ticks = 54000,
  parameter int gate_reset_ticks     = 540,
  parameter int max_retries          = 3
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  ramped_bldc_drive_ctl_if.slave bus
);

  localparam int rc_width = $clog2(max_retries + 1);
  localparam int rt_width = (ramp_interval_ticks > 1) ? $clog2(ramp_interval_ticks) : 1;
  localparam int wait_max = (reversal_dwell_ticks > gate_reset_ticks) ?
                            reversal_dwell_ticks : gate_reset_ticks;
  localparam int wt_width = (wait_max > 1) ? $clog2(wait_max) : 1;

  localparam logic [rt_width-1:0]   ramp_last  = rt_width'(ramp_interval_ticks - 1);
  localparam logic [wt_width-1:0]   dwell_last = wt_width'(reversal_dwell_ticks - 1);
  localparam logic [wt_width-1:0]   gate_last  = wt_width'(gate_reset_ticks - 1);
  localparam logic [duty_width-1:0] step_v     = duty_width'(ramp_step);
  localparam logic [rc_width-1:0]   retry_max  = rc_width'(max_retries);

  localparam logic [1:0] dir_none = 2'd0;
  localparam logic [1:0] dir_cw   = 2'd1;
  localparam logic [1:0] dir_ccw  = 2'd2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RAMP_UP    = 3'd1,
    RUN        = 3'd2,
    RAMP_DOWN  = 3'd3,
    DWELL      = 3'd4,
    GATE_RESET = 3'd5,
    ERROR      = 3'd6,
    LOCKOUT    = 3'd7
  } state_t;

  state_t                state;
  logic [duty_width-1:0] duty_q;
  logic [1:0]            dir_q;
  logic                  pwm_q;
  logic                  gate_q;
  logic                  pulse_q;
  logic                  lock_q;
  logic [rc_width-1:0]   retry_q;
  logic [rt_width-1:0]   ramp_timer;
  logic [wt_width-1:0]   wait_timer;

  logic                  ramp_tick;
  logic                  req_valid;
  logic                  req_reverse;
  logic [duty_width-1:0] slew_duty;
  logic [duty_width-1:0] down_duty;

  assign ramp_tick   = (ramp_timer == ramp_last);
  assign req_valid   = bus.enable && ((bus.direction == dir_cw) || (bus.direction == dir_ccw));
  assign req_reverse = bus.enable &&
                       (((dir_q == dir_cw)  && (bus.direction == dir_ccw)) ||
                        ((dir_q == dir_ccw) && (bus.direction == dir_cw)));

  // Step toward the target; the last partial step lands exactly on it, so no wrap is possible.
  always_comb begin
    slew_duty = duty_q;
    if (bus.duty_target > duty_q) begin
      slew_duty = ((bus.duty_target - duty_q) < step_v) ? bus.duty_target : duty_q + step_v;
    end else if (bus.duty_target < duty_q) begin
      slew_duty = ((duty_q - bus.duty_target) < step_v) ? bus.duty_target : duty_q - step_v;
    end
  end

  always_comb begin
    down_duty = (duty_q < step_v) ? '0 : duty_q - step_v;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= IDLE;
      duty_q     <= '0;
      dir_q      <= dir_none;
      pwm_q      <= 1'b0;
      gate_q     <= 1'b0;
      pulse_q    <= 1'b0;
      lock_q     <= 1'b0;
      retry_q    <= '0;
      ramp_timer <= '0;
      wait_timer <= '0;
    end else begin
      gate_q  <= bus.enable && !bus.hall_error &&
                 !(state inside {GATE_RESET, ERROR, LOCKOUT});
      pulse_q <= 1'b0;

      if (bus.hall_error && (state != LOCKOUT)) begin
        state  <= ERROR;
        duty_q <= '0;
        pwm_q  <= 1'b0;
        dir_q  <= dir_none;
      end else if (!bus.fault_n && (state inside {RAMP_UP, RUN, RAMP_DOWN})) begin
        duty_q     <= '0;
        pwm_q      <= 1'b0;
        dir_q      <= dir_none;
        wait_timer <= '0;
        if (retry_q < retry_max) begin
          state   <= GATE_RESET;
          retry_q <= retry_q + 1'b1;
          pulse_q <= 1'b1;
        end else begin
          state  <= LOCKOUT;
          lock_q <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              dir_q      <= bus.direction;
              pwm_q      <= 1'b1;
              ramp_timer <= '0;
              state      <= RAMP_UP;
            end
          end

          RAMP_UP, RUN: begin
            if (!bus.enable || (bus.direction != dir_q)) begin
              state      <= RAMP_DOWN;
              ramp_timer <= '0;
            end else begin
              ramp_timer <= ramp_tick ? '0 : ramp_timer + 1'b1;
              if (ramp_tick) duty_q <= slew_duty;
              if ((state == RAMP_UP) && (duty_q == bus.duty_target)) state <= RUN;
            end
          end

          // Once started, the ramp-down always completes before the request is re-examined.
          RAMP_DOWN: begin
            if (duty_q == '0) begin
              pwm_q <= 1'b0;
              dir_q <= dir_none;
              if (req_reverse) begin
                state      <= DWELL;
                wait_timer <= '0;
              end else begin
                state   <= IDLE;
                retry_q <= '0;
              end
            end else begin
              ramp_timer <= ramp_tick ? '0 : ramp_timer + 1'b1;
              if (ramp_tick) duty_q <= down_duty;
            end
          end

          DWELL: begin
            if (wait_timer == dwell_last) begin
              if (req_valid) begin
                dir_q      <= bus.direction;
                pwm_q      <= 1'b1;
                ramp_timer <= '0;
                state      <= RAMP_UP;
              end else begin
                state <= IDLE;
              end
            end else begin
              wait_timer <= wait_timer + 1'b1;
            end
          end

          GATE_RESET: begin
            if (wait_timer == gate_last) state <= IDLE;
            else wait_timer <= wait_timer + 1'b1;
          end

          ERROR: state <= IDLE;

          LOCKOUT: begin
            if (bus.clear_lockout && !bus.enable) begin
              state   <= IDLE;
              lock_q  <= 1'b0;
              retry_q <= '0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.duty_out         = duty_q;
  assign bus.dir_out          = dir_q;
  assign bus.pwm_enable       = pwm_q;
  assign bus.gate_enable      = gate_q;
  assign bus.gate_reset_pulse = pulse_q;
  assign bus.retry_count      = retry_q;
  assign bus.lockout          = lock_q;
  assign bus.driver_state     = state;

endmodule
